// File: rtl/prbs_pkg.sv
// Shared definitions for the PRBS-15 error checker.
//   state_t      : checker FSM states
//   PRBS_LEN     : LFSR length (history register width)
//   TAP_A/TAP_B  : recurrence taps, b[k] = b[k-TAP_A] ^ b[k-TAP_B]
//   popcount8()  : number of set bits in a byte
package prbs_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    localparam int PRBS_LEN = 15;
    localparam int TAP_A    = 14;
    localparam int TAP_B    = 15;

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/prbs15_byte_predictor.sv
// Combinational one-byte look-ahead for PRBS-15 (x^15 + x^14 + 1).
//   hist      : history, hist[0] = most recent bit, hist[14] = oldest
//   pred      : next 8 predicted bits, pred[7] earliest in time
//   hist_next : history advanced by the 8 predicted bits
// Because the nearest tap is 14 bits back, every predicted bit of the
// byte depends only on bits from earlier bytes.
module prbs15_byte_predictor
    import prbs_pkg::*;
(
    input  logic [PRBS_LEN-1:0] hist,
    output logic [7:0]          pred,
    output logic [PRBS_LEN-1:0] hist_next
);

    logic [PRBS_LEN-1:0] h;
    logic                nb;

    always_comb begin
        h    = hist;
        nb   = 1'b0;
        pred = '0;
        for (int i = 7; i >= 0; i--) begin
            nb      = h[TAP_A-1] ^ h[TAP_B-1];
            pred[i] = nb;
            h       = {h[PRBS_LEN-2:0], nb};
        end
        hist_next = h;
    end

endmodule

// File: rtl/prbs_err_checker.sv
// PRBS-15 byte-wide error checker with HUNT/VERIFY/LOCKED acquisition.
//   CLK, RST   : clock, synchronous active-high reset
//   in         : received byte, bit 7 earliest in time
//   in_valid   : qualifies in; invalid cycles are ignored
//   clr_counts : clears err_count and byte_count (wins over increment)
//   locked     : registered, high while in LOCKED
//   err_mask   : per-bit mismatch of the last checked byte
//   err_valid  : one-cycle strobe for err_mask (LOCKED only)
//   err_count  : saturating bit-error total while locked
//   byte_count : saturating checked-byte total while locked
module prbs_err_checker
    import prbs_pkg::*;
#(
    parameter int VERIFY_BYTES = 4,
    parameter int LOSS_THRESH  = 4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [7:0]  in,
    input  logic        in_valid,
    input  logic        clr_counts,
    output logic        locked,
    output logic [7:0]  err_mask,
    output logic        err_valid,
    output logic [31:0] err_count,
    output logic [31:0] byte_count
);

    state_t              state;
    logic [PRBS_LEN-1:0] hist;
    logic                fill_cnt;
    logic [15:0]         clean_cnt;
    logic [15:0]         bad_cnt;

    logic [7:0]          pred;
    logic [PRBS_LEN-1:0] pred_hist;
    logic [7:0]          mask;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [3:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {29'd0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // One predictor serves both paths: in VERIFY hist holds received
    // bits (self-synchronous), in LOCKED it holds only predicted bits.
    prbs15_byte_predictor u_pred (
        .hist      (hist),
        .pred      (pred),
        .hist_next (pred_hist)
    );

    assign mask = in ^ pred;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= HUNT;
            hist       <= '0;
            fill_cnt   <= 1'b0;
            clean_cnt  <= '0;
            bad_cnt    <= '0;
            locked     <= 1'b0;
            err_mask   <= '0;
            err_valid  <= 1'b0;
            err_count  <= '0;
            byte_count <= '0;
        end else begin
            err_valid <= 1'b0;

            if (in_valid) begin
                case (state)
                    HUNT: begin
                        hist <= {hist[PRBS_LEN-9:0], in};
                        if (fill_cnt) begin
                            state     <= VERIFY;
                            fill_cnt  <= 1'b0;
                            clean_cnt <= '0;
                        end else begin
                            fill_cnt <= 1'b1;
                        end
                    end
                    VERIFY: begin
                        hist <= {hist[PRBS_LEN-9:0], in};
                        if (|mask) begin
                            clean_cnt <= '0;
                        end else if (clean_cnt + 16'd1 == 16'(VERIFY_BYTES)) begin
                            state     <= LOCKED;
                            locked    <= 1'b1;
                            clean_cnt <= '0;
                            bad_cnt   <= '0;
                        end else begin
                            clean_cnt <= clean_cnt + 16'd1;
                        end
                    end
                    LOCKED: begin
                        // Free-running reference: received bits never
                        // enter the history, so one bit error stays one.
                        hist      <= pred_hist;
                        err_mask  <= mask;
                        err_valid <= 1'b1;
                        if (|mask) begin
                            if (bad_cnt + 16'd1 == 16'(LOSS_THRESH)) begin
                                state     <= HUNT;
                                locked    <= 1'b0;
                                bad_cnt   <= '0;
                                fill_cnt  <= 1'b0;
                                clean_cnt <= '0;
                            end else begin
                                bad_cnt <= bad_cnt + 16'd1;
                            end
                        end else begin
                            bad_cnt <= '0;
                        end
                    end
                    default: begin
                        state  <= HUNT;
                        locked <= 1'b0;
                    end
                endcase
            end

            if (clr_counts) begin
                err_count  <= '0;
                byte_count <= '0;
            end else if (in_valid && state == LOCKED) begin
                err_count  <= sat_add(err_count, popcount8(mask));
                byte_count <= sat_add(byte_count, 4'd1);
            end
        end
    end

endmodule

// File: tb/tb_prbs_err_checker.sv
// Self-checking bench for prbs_err_checker: acquisition, error injection,
// loss/relock, count clearing, gapped input and mid-stream reset.
module tb_prbs_err_checker;

    logic        CLK = 1'b0;
    logic        RST;
    logic [7:0]  in;
    logic        in_valid;
    logic        clr_counts;
    logic        locked;
    logic [7:0]  err_mask;
    logic        err_valid;
    logic [31:0] err_count;
    logic [31:0] byte_count;

    always #5 CLK = ~CLK;

    prbs_err_checker #(
        .VERIFY_BYTES (4),
        .LOSS_THRESH  (4)
    ) dut (
        .CLK        (CLK),
        .RST        (RST),
        .in         (in),
        .in_valid   (in_valid),
        .clr_counts (clr_counts),
        .locked     (locked),
        .err_mask   (err_mask),
        .err_valid  (err_valid),
        .err_count  (err_count),
        .byte_count (byte_count)
    );

    typedef struct {
        logic [7:0]  x;
        logic        clr;
        logic        ev;
        logic        lk;
        logic [31:0] ec;
        logic [31:0] bc;
    } vec_t;

    vec_t        vecs[15];
    logic [14:0] gen;
    logic [7:0]  sb_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference PRBS-15 source: b[k] = b[k-14] ^ b[k-15], bit 7 first.
    task automatic next_byte(output logic [7:0] b);
        logic nb;
        for (int i = 7; i >= 0; i--) begin
            nb   = gen[13] ^ gen[14];
            gen  = {gen[13:0], nb};
            b[i] = nb;
        end
    endtask

    task automatic tick(input logic exp_ev);
        logic [7:0] e;
        @(posedge CLK);
        #1;
        chk("err_valid", {31'd0, err_valid}, {31'd0, exp_ev});
        if (err_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL err_mask: got %h with no expected entry at %0t", err_mask, $time);
            end else begin
                e = sb_q.pop_front();
                chk("err_mask", {24'd0, err_mask}, {24'd0, e});
            end
        end else if (exp_ev) begin
            void'(sb_q.pop_front());
        end
    endtask

    task automatic drive_byte(input logic v, input logic [7:0] x, input logic clr, input logic exp_ev);
        logic [7:0] b;
        if (v) begin
            next_byte(b);
            in = b ^ x;
        end else begin
            in = 8'($urandom);
        end
        in_valid   = v;
        clr_counts = clr;
        if (exp_ev) sb_q.push_back(x);
        tick(exp_ev);
        in_valid   = 1'b0;
        clr_counts = 1'b0;
    endtask

    task automatic do_reset(input int n);
        RST      = 1'b1;
        in_valid = 1'b0;
        repeat (n) tick(1'b0);
        RST = 1'b0;
    endtask

    initial begin
        RST        = 1'b1;
        in         = '0;
        in_valid   = 1'b0;
        clr_counts = 1'b0;
        gen        = 15'h7FFF;

        vecs[0]  = '{8'h08, 1'b0, 1'b1, 1'b1, 32'd1,  32'd101};
        vecs[1]  = '{8'h00, 1'b0, 1'b1, 1'b1, 32'd1,  32'd102};
        vecs[2]  = '{8'h00, 1'b1, 1'b1, 1'b1, 32'd0,  32'd0};
        vecs[3]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 32'd8,  32'd1};
        vecs[4]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 32'd16, 32'd2};
        vecs[5]  = '{8'hFF, 1'b0, 1'b1, 1'b1, 32'd24, 32'd3};
        vecs[6]  = '{8'hFF, 1'b0, 1'b1, 1'b0, 32'd32, 32'd4};
        for (int i = 7; i < 12; i++) vecs[i] = '{8'h00, 1'b0, 1'b0, 1'b0, 32'd32, 32'd4};
        vecs[12] = '{8'h00, 1'b0, 1'b0, 1'b1, 32'd32, 32'd4};
        vecs[13] = '{8'h07, 1'b1, 1'b1, 1'b1, 32'd0,  32'd0};
        vecs[14] = '{8'h00, 1'b0, 1'b1, 1'b1, 32'd0,  32'd1};

        // Reset state
        do_reset(3);
        chk("rst_locked", {31'd0, locked}, 32'd0);
        chk("rst_err_count", err_count, 32'd0);
        chk("rst_byte_count", byte_count, 32'd0);
        chk("rst_err_mask", {24'd0, err_mask}, 32'd0);

        // Clean acquisition: lock on the 6th byte
        for (int i = 1; i <= 6; i++) begin
            drive_byte(1'b1, 8'h00, 1'b0, 1'b0);
            chk($sformatf("acq_locked_%0d", i), {31'd0, locked}, {31'd0, (i == 6)});
        end
        for (int i = 0; i < 100; i++) drive_byte(1'b1, 8'h00, 1'b0, 1'b1);
        chk("clean_err_count", err_count, 32'd0);
        chk("clean_byte_count", byte_count, 32'd100);
        chk("clean_locked", {31'd0, locked}, 32'd1);

        // Error injection, loss of lock, relock and count clearing
        for (int i = 0; i < 15; i++) begin
            drive_byte(1'b1, vecs[i].x, vecs[i].clr, vecs[i].ev);
            chk($sformatf("vec%0d_locked", i), {31'd0, locked}, {31'd0, vecs[i].lk});
            chk($sformatf("vec%0d_err_count", i), err_count, vecs[i].ec);
            chk($sformatf("vec%0d_byte_count", i), byte_count, vecs[i].bc);
        end

        // Gapped input: valid every other cycle, lock after 11 cycles
        do_reset(3);
        for (int c = 1; c <= 11; c++) begin
            drive_byte((c % 2) == 1, 8'h00, 1'b0, 1'b0);
            chk($sformatf("gap_locked_c%0d", c), {31'd0, locked}, {31'd0, (c == 11)});
        end
        for (int c = 12; c <= 15; c++) begin
            drive_byte((c % 2) == 1, 8'h00, 1'b0, (c % 2) == 1);
        end
        chk("gap_byte_count", byte_count, 32'd2);

        // Mid-stream reset discards lock; full reacquisition needed
        do_reset(1);
        chk("mid_rst_locked", {31'd0, locked}, 32'd0);
        for (int i = 1; i <= 6; i++) begin
            drive_byte(1'b1, 8'h00, 1'b0, 1'b0);
            chk($sformatf("reacq_locked_%0d", i), {31'd0, locked}, {31'd0, (i == 6)});
        end

        chk("sb_empty", sb_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/prbs_err_checker.md
PRBS_ERR_CHECKER -- requirements
Module: prbs_err_checker

Interface
REQ-001 SHALL have parameter VERIFY_BYTES, default 4, consecutive clean bytes needed to declare lock.
REQ-002 SHALL have parameter LOSS_THRESH, default 4, consecutive errored bytes that drop lock.
REQ-003 SHALL have port CLK  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port RST  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in  input  8  received PRBS byte; bit 7 is earliest in time.
REQ-006 SHALL have port in_valid  input  1  qualifies in; bytes with in_valid=0 are ignored entirely.
REQ-007 SHALL have port clr_counts  input  1  synchronous clear of err_count and byte_count.
REQ-008 SHALL have port locked  output  1  high while the FSM is in LOCKED.
REQ-009 SHALL have port err_mask  output  8  per-bit mismatch of the last checked byte.
REQ-010 SHALL have port err_valid  output  1  err_mask valid for one cycle.
REQ-011 SHALL have port err_count  output  32  saturating total of bit errors while locked.
REQ-012 SHALL have port byte_count  output  32  saturating total of bytes checked while locked.

Function
REQ-013 SHALL check PRBS-15 (x^15+x^14+1): expected bit b[k] = b[k-14] XOR b[k-15].
REQ-014 SHALL hold a 15-bit history register; all 8 predicted bits of a byte depend only on earlier bytes and SHALL be computed in one cycle.
REQ-015 SHALL implement FSM states HUNT, VERIFY, LOCKED.
REQ-016 HUNT: shift each valid byte into history; after the 2nd valid byte since entry, go to VERIFY.
REQ-017 VERIFY: predict from received history (self-synchronous); zero-mismatch byte increments clean counter, any mismatch resets it to 0; history always loads received byte.
REQ-018 VERIFY -> LOCKED on the edge where clean counter reaches VERIFY_BYTES; history then continues as free-running reference LFSR.
REQ-019 LOCKED: history advances 8 bits per valid byte using predicted bits only, never received bits (no error multiplication).
REQ-020 LOCKED: err_mask = in XOR predicted, err_valid=1 on the edge after the valid byte; err_valid=0 in HUNT/VERIFY.
REQ-021 LOCKED: err_count += popcount(err_mask), byte_count += 1, on same edge err_valid asserts; both saturate at 32'hFFFF_FFFF.
REQ-022 LOCKED: byte with any mismatch increments errored-byte counter, clean byte resets it; reaching LOSS_THRESH -> HUNT on that edge, fill and clean counters cleared, err_count/byte_count retained.
REQ-023 clr_counts SHALL win over a simultaneous increment (counters = 0 after that edge).
REQ-024 locked SHALL be a registered decode of state, changing on the transition edge.

Reset
REQ-025 RST=1 SHALL force state HUNT, history 0, all internal counters 0, locked=0, err_valid=0, err_mask=0, err_count=0, byte_count=0.
REQ-026 RST mid-stream SHALL discard lock; reacquisition requires a full HUNT+VERIFY sequence.

Structure
REQ-027 Package prbs_pkg SHALL hold the state enum, PRBS-15 length/tap constants, and an 8-bit popcount function.
REQ-028 Sub-module prbs15_byte_predictor (combinational: 15-bit history in, 8 predicted bits and next history out) SHALL be used for both VERIFY and LOCKED paths.

Verification
REQ-029 Reset asserted 3 cycles -> locked=0, err_valid=0, err_count=0, byte_count=0.
REQ-030 Clean PRBS-15 stream (generator seed 15'h7FFF), in_valid=1 -> locked rises at edge of 6th byte; after 100 more bytes err_count=0, byte_count=100.
REQ-031 Locked, flip bit 3 of one byte -> err_mask=8'h08 with err_valid=1, err_count=1; following byte err_mask=8'h00.
REQ-032 Locked, 4 consecutive bytes XOR 8'hFF -> err_count=32, locked falls at edge of 4th; next 6 clean bytes -> relock, err_count still 32.
REQ-033 Clean stream with in_valid toggling 1/0 each cycle -> lock after 6 valid bytes (11 cycles); invalid cycles never assert err_valid.
REQ-034 clr_counts=1 on same edge as an errored byte (3 bit errors) -> err_count=0 and byte_count=0 after that edge.
